// File: rtl/datamem_pkg.sv
// Shared types and lane helpers for the load/store data memory.
// The helpers work on a 64-bit word; 32-bit callers truncate the result.
package datamem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Per-request bookkeeping that travels alongside the read data.
    typedef struct packed {
        logic       valid;
        logic       err;
        logic       we;
        logic [1:0] size;
        logic [2:0] offset;
        logic       is_unsigned;
    } rsp_meta_t;

    function automatic logic [7:0] byte_en(input logic [1:0] size, input logic [2:0] offset);
        logic [7:0] mask;
        case (size)
            SZ_B:    mask = 8'h01;
            SZ_H:    mask = 8'h03;
            SZ_W:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask << offset;
    endfunction

    function automatic logic [63:0] load_extend(input logic [63:0] word, input logic [1:0] size,
                                                input logic [2:0] offset, input logic is_unsigned);
        logic [63:0] shifted;
        shifted = word >> {offset, 3'b000};
        case (size)
            SZ_B:    return is_unsigned ? {56'b0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
            SZ_H:    return is_unsigned ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            SZ_W:    return is_unsigned ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            default: return shifted;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return addr_lo[0];
            SZ_W:    return |addr_lo[1:0];
            default: return |addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/datamem_lsu_if.sv
// Request/response bus between the core memory stage and the data memory.
interface datamem_lsu_if
    import datamem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    size_e             req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/datamem_bank.sv
// DEPTH x DATA_W storage with per-byte write enables and a registered read port.
module datamem_bank #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 1024,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int LANES  = DATA_W / 8
) (
    input  logic              datamem_clk,
    input  logic              we,
    input  logic [LANES-1:0]  be,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto RAM; the owner clears it by writing zeros.
    always_ff @(posedge datamem_clk) begin
        if (we) begin
            for (int b = 0; b < LANES; b++) begin
                if (be[b]) mem[wr_idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        if (re) rdata <= mem[rd_idx];
    end

endmodule

// File: rtl/datamem_lsu.sv
// Load/store unit: clears the array after reset, then serves byte..dword
// accesses with alignment/range checks and an RD_LAT-cycle response pipeline.
module datamem_lsu
    import datamem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input logic          datamem_lsu_clk,
    input logic          datamem_lsu_rst,
    datamem_lsu_if.slave bus
);

    localparam int LANES  = DATA_W / 8;
    localparam int LANE_W = $clog2(LANES);
    localparam int IDX_W  = $clog2(DEPTH);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  clr_cnt_q;

    logic              accept;
    logic [2:0]        req_off;
    logic [ADDR_W-1:0] req_word;
    logic              req_err;

    logic              bank_we;
    logic [LANES-1:0]  bank_be;
    logic [IDX_W-1:0]  bank_wr_idx;
    logic [DATA_W-1:0] bank_wdata;
    logic              bank_re;
    logic [DATA_W-1:0] bank_rdata;

    rsp_meta_t         meta_in;
    rsp_meta_t         meta_q [RD_LAT];
    rsp_meta_t         tail;
    logic [DATA_W-1:0] out_word;

    always_ff @(posedge datamem_lsu_clk or posedge datamem_lsu_rst) begin
        if (datamem_lsu_rst) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) clr_cnt_q <= clr_cnt_q + IDX_W'(1);
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (clr_cnt_q == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    assign bus.req_ready = (state_q == ST_RUN);
    assign accept        = bus.req_valid && bus.req_ready;

    assign req_off  = 3'(bus.req_addr[LANE_W-1:0]);
    assign req_word = bus.req_addr >> LANE_W;
    assign req_err  = is_misaligned(bus.req_addr[2:0], bus.req_size)
                   || (req_word >= ADDR_W'(DEPTH))
                   || (int'(bus.req_size) > LANE_W);

    // The clear sequence owns the write port until RUN.
    always_comb begin
        bank_we     = 1'b0;
        bank_be     = '0;
        bank_wr_idx = '0;
        bank_wdata  = '0;
        if (state_q == ST_INIT) begin
            bank_we     = 1'b1;
            bank_be     = '1;
            bank_wr_idx = clr_cnt_q;
        end else if (accept && bus.req_we && !req_err) begin
            bank_we     = 1'b1;
            bank_be     = LANES'(byte_en(bus.req_size, req_off));
            bank_wr_idx = req_word[IDX_W-1:0];
            bank_wdata  = bus.req_wdata << {req_off, 3'b000};
        end
    end

    assign bank_re = accept && !bus.req_we && !req_err;

    datamem_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_bank (
        .datamem_clk (datamem_lsu_clk),
        .we          (bank_we),
        .be          (bank_be),
        .wr_idx      (bank_wr_idx),
        .wdata       (bank_wdata),
        .re          (bank_re),
        .rd_idx      (req_word[IDX_W-1:0]),
        .rdata       (bank_rdata)
    );

    always_comb begin
        meta_in             = '0;
        meta_in.valid       = accept;
        meta_in.err         = req_err;
        meta_in.we          = bus.req_we;
        meta_in.size        = bus.req_size;
        meta_in.offset      = req_off;
        meta_in.is_unsigned = bus.req_unsigned;
    end

    // Reset empties the pipeline so in-flight responses are dropped.
    always_ff @(posedge datamem_lsu_clk or posedge datamem_lsu_rst) begin
        if (datamem_lsu_rst) begin
            for (int i = 0; i < RD_LAT; i++) meta_q[i] <= '0;
        end else begin
            meta_q[0] <= meta_in;
            for (int i = 1; i < RD_LAT; i++) meta_q[i] <= meta_q[i-1];
        end
    end

    // The bank register is the first read stage; extra latency delays the word to match.
    generate
        if (RD_LAT == 1) begin : g_lat1
            assign out_word = bank_rdata;
        end else begin : g_latn
            logic [DATA_W-1:0] word_q [RD_LAT-1];
            always_ff @(posedge datamem_lsu_clk) begin
                word_q[0] <= bank_rdata;
                for (int i = 1; i < RD_LAT - 1; i++) word_q[i] <= word_q[i-1];
            end
            assign out_word = word_q[RD_LAT-2];
        end
    endgenerate

    assign tail = meta_q[RD_LAT-1];

    always_comb begin
        bus.rsp_valid = tail.valid;
        bus.rsp_err   = tail.valid && tail.err;
        bus.rsp_rdata = '0;
        if (tail.valid && !tail.err && !tail.we) begin
            bus.rsp_rdata = DATA_W'(load_extend(64'(out_word), tail.size, tail.offset, tail.is_unsigned));
        end
    end

endmodule

// File: tb/tb_datamem_lsu.sv
// Randomised and directed bench for datamem_lsu against a byte-array reference model.
module tb_datamem_lsu;
    import datamem_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 32;
    localparam int RD_LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    datamem_lsu_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    datamem_lsu #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .datamem_lsu_clk (clk),
        .datamem_lsu_rst (rst),
        .bus             (bus)
    );

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
        bit          has_lit;
        logic [31:0] lit_rdata;
        logic        lit_err;
    } exp_t;

    exp_t        exp_q[$];
    byte unsigned mem_m [DEPTH*4];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference behaviour: byte-addressed little-endian memory.
    function automatic void model(input bit we, input int sz, input bit uns, input logic [31:0] addr,
                                  input logic [31:0] wdata, output logic [31:0] rd, output logic err);
        longint unsigned val;
        int nbytes;
        nbytes = 1 << sz;
        rd  = '0;
        err = (addr % nbytes != 0) || (addr / 4 >= DEPTH) || (sz > 2);
        if (err) return;
        if (we) begin
            for (int b = 0; b < nbytes; b++) mem_m[addr + b] = wdata[8*b +: 8];
        end else begin
            val = 0;
            for (int b = 0; b < nbytes; b++) val |= longint'(mem_m[addr + b]) << (8 * b);
            if (!uns && val[8*nbytes-1]) val |= ~((64'd1 << (8 * nbytes)) - 64'd1);
            rd = val[31:0];
        end
    endfunction

    task automatic issue(input bit we, input int sz, input bit uns, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit has_lit = 1'b0,
                         input logic [31:0] lit_rd = '0, input logic lit_err = 1'b0);
        exp_t        e;
        logic [31:0] rd;
        logic        err;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size_e'(sz[1:0]);
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        check("req_ready", bus.req_ready, 1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        model(we, sz, uns, addr, wdata, rd, err);
        e.due       = cyc + RD_LAT - 1;
        e.rdata     = rd;
        e.err       = err;
        e.has_lit   = has_lit;
        e.lit_rdata = lit_rd;
        e.lit_err   = lit_err;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // A store presented during the clear sequence must be ignored.
    task automatic wait_init();
        int n;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = SZ_W;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'hDEAD_BEEF;
        while (!bus.req_ready && n < DEPTH + 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        bus.req_valid = 1'b0;
        check("init_cycles", 64'(n), 64'(DEPTH));
    endtask

    task automatic apply_reset();
        bus.req_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        foreach (mem_m[i]) mem_m[i] = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_init();
    endtask

    always @(negedge clk) begin
        bit   exp_v;
        exp_t e;
        exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        check("rsp_valid", bus.rsp_valid, exp_v);
        if (exp_v) begin
            e = exp_q.pop_front();
            check("rsp_err", bus.rsp_err, e.err);
            check("rsp_rdata", bus.rsp_rdata, e.rdata);
            if (e.has_lit) begin
                check("plan_err", bus.rsp_err, e.lit_err);
                check("plan_rdata", bus.rsp_rdata, e.lit_rdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = SZ_B;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        foreach (mem_m[i]) mem_m[i] = 8'h00;

        repeat (3) @(negedge clk);
        check("reset_ready", bus.req_ready, 0);
        check("reset_rdata", bus.rsp_rdata, 0);
        check("reset_err", bus.rsp_err, 0);
        rst = 1'b0;
        wait_init();

        // Directed sequence, issued back to back.
        issue(0, 2, 0, 32'h0, 0, 1, 32'h0, 0);
        issue(0, 2, 0, 32'(4 * (DEPTH - 1)), 0, 1, 32'h0, 0);
        issue(1, 2, 0, 32'h10, 32'h8081_8283, 1, 32'h0, 0);
        issue(0, 0, 0, 32'h11, 0, 1, 32'hFFFF_FF82, 0);
        issue(0, 0, 1, 32'h11, 0, 1, 32'h0000_0082, 0);
        issue(0, 1, 0, 32'h12, 0, 1, 32'hFFFF_8081, 0);
        issue(1, 0, 0, 32'h13, 32'h0000_00AA, 1, 32'h0, 0);
        issue(0, 2, 0, 32'h10, 0, 1, 32'hAA81_8283, 0);
        issue(0, 1, 0, 32'h11, 0, 1, 32'h0, 1);
        issue(1, 2, 0, 32'(4 * DEPTH), 32'h1234_5678, 1, 32'h0, 1);
        issue(0, 2, 0, 32'h0, 0, 1, 32'h0, 0);
        issue(0, 3, 0, 32'h8, 0, 1, 32'h0, 1);
        issue(1, 1, 0, 32'h2, 32'h0000_F00D, 1, 32'h0, 0);
        issue(0, 2, 1, 32'h0, 0, 1, 32'hF00D_0000, 0);
        idle(4);

        for (int i = 0; i < 400; i++) begin
            int          sz;
            logic [31:0] addr;
            if ($urandom_range(0, 4) == 0) idle(1);
            sz = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) addr = 32'(4 * DEPTH) + 32'($urandom_range(0, 63));
            else addr = 32'($urandom_range(0, 4 * DEPTH - 1));
            if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << sz) - 32'd1);
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, 32'($urandom));
        end
        idle(RD_LAT + 2);

        // Reset one cycle after a load is accepted: the load must never respond.
        issue(1, 2, 0, 32'h20, 32'h5A5A_1234, 1, 32'h0, 0);
        idle(RD_LAT + 1);
        issue(0, 2, 0, 32'h20, 0, 1, 32'h5A5A_1234, 0);
        @(posedge clk);
        #1;
        apply_reset();
        issue(0, 2, 0, 32'h20, 0, 1, 32'h0, 0);
        issue(0, 2, 0, 32'h10, 0, 1, 32'h0, 0);

        n = 0;
        while (exp_q.size() > 0 && n < RD_LAT + 8) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
